// File: rtl/onn_neuron_bank_sync_pkg.sv
// ---------------------------------------------------------------------------
// onn_neuron_bank_sync_pkg
//   Shared definitions for the ONN oscillator bank.
//   - step_e   : per-cycle phase increment selected by the coupling input
//   - step_sel : maps (coupling input, oscillator output) to a step
// No ports; imported by onn_neuron_bank_sync and onn_neuron_bank_sync_core.
// ---------------------------------------------------------------------------
package onn_neuron_bank_sync_pkg;

    // Phase increment applied on a run cycle.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,   // retard: phase stays put while the reference moves on
        STEP_NORM = 2'd1,   // free-running: phase tracks the reference
        STEP_ADV  = 2'd2    // advance: phase gains one step on the reference
    } step_e;

    // Coupling rule: agreement keeps the normal rate, a high coupling input
    // on a low oscillator pulls it forward, a low input on a high oscillator
    // holds it back.
    function automatic step_e step_sel(input logic nin, input logic nout);
        step_e s;
        if (nin == nout) begin
            s = STEP_NORM;
        end else if (nin) begin
            s = STEP_ADV;
        end else begin
            s = STEP_HOLD;
        end
        return s;
    endfunction

endpackage

// File: rtl/onn_neuron_bank_sync_core.sv
// ---------------------------------------------------------------------------
// onn_neuron_bank_sync_core
//   One oscillator neuron: phase accumulator with coupling-controlled step,
//   output decode, and the period-boundary state snapshot.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   run, load       advance / bulk-load strobes (load has priority)
//   boundary        this run edge closes a reference period (already
//                   qualified with run and not load by the parent)
//   ini_phase       phase loaded on load
//   ref_next        reference phase after this edge's increment
//   nin             coupling input
//   nout            1 while phase is in the lower half of the period
//   phase           current phase
//   change_next     state bit would flip if this edge were a boundary
//   state_changed   registered flip flag from the last boundary
// ---------------------------------------------------------------------------
module onn_neuron_bank_sync_core
    import onn_neuron_bank_sync_pkg::*;
#(
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         load,
    input  logic         boundary,
    input  logic [P-1:0] ini_phase,
    input  logic [P-1:0] ref_next,
    input  logic         nin,
    output logic         nout,
    output logic [P-1:0] phase,
    output logic         change_next,
    output logic         state_changed
);

    localparam logic [P-1:0] HALF = P'(1) << (P - 1);

    step_e        step;
    logic [P-1:0] phase_next;
    logic [P-1:0] rel;
    logic         new_state;
    logic         snapshot;

    // Pure decode of the phase register: nin only reaches nout via a flop.
    assign nout = ~phase[P-1];

    always_comb begin
        step        = step_sel(nin, nout);
        phase_next  = phase + P'(step);
        // Phase relative to the reference, both taken after this edge.
        rel         = phase_next - ref_next;
        new_state   = (rel >= HALF);
        change_next = new_state ^ snapshot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase         <= '0;
            snapshot      <= 1'b0;
            state_changed <= 1'b0;
        end else if (load) begin
            phase         <= ini_phase;
            snapshot      <= ini_phase[P-1];
            state_changed <= 1'b0;
        end else if (run) begin
            phase <= phase_next;
            if (boundary) begin
                state_changed <= change_next;
                snapshot      <= new_state;
            end
        end
    end

endmodule

// File: rtl/onn_neuron_bank_sync.sv
// ---------------------------------------------------------------------------
// onn_neuron_bank_sync
//   N-neuron oscillator bank with a shared reference phase counter, a
//   per-period snapshot of each neuron's in/anti-phase state and a
//   convergence detector.
// Ports:
//   sclk, re_n      clock (rising edge), asynchronous active-low reset
//   run             advance oscillators and reference this cycle
//   load            load ini_phase into all neurons, clear reference
//   ini_phase       N*P initial phases, neuron i at [P*i +: P]
//   nin             N coupling inputs
//   nout            N oscillator outputs
//   phi_out         N*P current phases, same packing as ini_phase
//   state_changed   N flip flags from the last period boundary
//   period_done     one-cycle pulse after each period boundary edge
//   stable_cnt      consecutive periods without any flip, saturating
//   converged       stable_cnt has reached STABLE_PERIODS
// ---------------------------------------------------------------------------
module onn_neuron_bank_sync
    import onn_neuron_bank_sync_pkg::*;
#(
    parameter  int N              = 210,
    parameter  int P              = 4,
    parameter  int STABLE_PERIODS = 4,
    localparam int SC_W           = $clog2(STABLE_PERIODS + 1)
) (
    input  logic            sclk,
    input  logic            re_n,
    input  logic            run,
    input  logic            load,
    input  logic [N*P-1:0]  ini_phase,
    input  logic [N-1:0]    nin,
    output logic [N-1:0]    nout,
    output logic [N*P-1:0]  phi_out,
    output logic [N-1:0]    state_changed,
    output logic            period_done,
    output logic [SC_W-1:0] stable_cnt,
    output logic            converged
);

    localparam logic [SC_W-1:0] STABLE_MAX = SC_W'(STABLE_PERIODS);

    logic [P-1:0]    ref_q;
    logic [P-1:0]    ref_next;
    logic            boundary;
    logic [N-1:0]    changes;
    logic            any_change;
    logic [SC_W-1:0] stable_next;

    // Boundary: the run edge on which the reference wraps; load overrides it.
    assign ref_next   = ref_q + P'(1);
    assign boundary   = run & ~load & (&ref_q);
    assign any_change = |changes;

    always_comb begin
        stable_next = stable_cnt;
        if (any_change) begin
            stable_next = '0;
        end else if (stable_cnt != STABLE_MAX) begin
            stable_next = stable_cnt + SC_W'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_neuron
        onn_neuron_bank_sync_core #(
            .P (P)
        ) u_core (
            .clk           (sclk),
            .rst_n         (re_n),
            .run           (run),
            .load          (load),
            .boundary      (boundary),
            .ini_phase     (ini_phase[P*i +: P]),
            .ref_next      (ref_next),
            .nin           (nin[i]),
            .nout          (nout[i]),
            .phase         (phi_out[P*i +: P]),
            .change_next   (changes[i]),
            .state_changed (state_changed[i])
        );
    end

    always_ff @(posedge sclk or negedge re_n) begin
        if (!re_n) begin
            ref_q       <= '0;
            period_done <= 1'b0;
            stable_cnt  <= '0;
            converged   <= 1'b0;
        end else if (load) begin
            ref_q       <= '0;
            period_done <= 1'b0;
            stable_cnt  <= '0;
            converged   <= 1'b0;
        end else if (run) begin
            ref_q       <= ref_next;
            period_done <= boundary;
            if (boundary) begin
                stable_cnt <= stable_next;
                converged  <= (stable_next == STABLE_MAX);
            end
        end else begin
            period_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_onn_neuron_bank_sync.sv
// ---------------------------------------------------------------------------
// tb_onn_neuron_bank_sync
//   Bench for onn_neuron_bank_sync with N=4, P=4, STABLE_PERIODS=3.
//   The reference model keeps phases as integers and applies the coupling
//   and period rules with plain modular arithmetic.
// ---------------------------------------------------------------------------
module tb_onn_neuron_bank_sync;

    localparam int N    = 4;
    localparam int P    = 4;
    localparam int SP   = 3;
    localparam int SC_W = $clog2(SP + 1);
    localparam int PER  = 1 << P;
    localparam int TW   = N * P + 3 * N + SC_W + 2;

    logic            sclk = 1'b0;
    logic            re_n;
    logic            run;
    logic            load;
    logic [N*P-1:0]  ini_phase;
    logic [N-1:0]    nin;
    logic [N-1:0]    nout;
    logic [N*P-1:0]  phi_out;
    logic [N-1:0]    state_changed;
    logic            period_done;
    logic [SC_W-1:0] stable_cnt;
    logic            converged;

    int n_tests = 0;
    int n_fail  = 0;

    onn_neuron_bank_sync #(
        .N              (N),
        .P              (P),
        .STABLE_PERIODS (SP)
    ) dut (
        .sclk          (sclk),
        .re_n          (re_n),
        .run           (run),
        .load          (load),
        .ini_phase     (ini_phase),
        .nin           (nin),
        .nout          (nout),
        .phi_out       (phi_out),
        .state_changed (state_changed),
        .period_done   (period_done),
        .stable_cnt    (stable_cnt),
        .converged     (converged)
    );

    // ---------------- clock ----------------
    always #5 sclk = ~sclk;

    // ---------------- reference model ----------------
    int          m_phase [N];
    int          m_ref;
    logic [N-1:0] m_snap;
    logic [N-1:0] m_chg;
    int          m_stable;
    logic        m_conv;
    logic        m_pd;

    function automatic logic [N-1:0] m_nout();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_phase[i] < PER / 2);
        return r;
    endfunction

    function automatic logic [N*P-1:0] m_phi();
        logic [N*P-1:0] r;
        for (int i = 0; i < N; i++) r[P*i +: P] = P'(m_phase[i]);
        return r;
    endfunction

    function automatic logic [TW-1:0] m_all();
        return {m_phi(), m_nout(), m_chg, m_pd, SC_W'(m_stable), m_conv};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_phase[i] = 0;
        m_ref = 0; m_snap = '0; m_chg = '0; m_stable = 0; m_conv = 1'b0; m_pd = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic r,
                              input logic [N*P-1:0] ini, input logic [N-1:0] ni);
        logic [N-1:0] no;
        logic         any;
        logic         nw;
        int           rel;
        bit           bnd;
        no = m_nout();
        if (l) begin
            for (int i = 0; i < N; i++) begin
                m_phase[i] = int'(ini[P*i +: P]);
                m_snap[i]  = ini[P*i + P - 1];
            end
            m_ref = 0; m_chg = '0; m_stable = 0; m_conv = 1'b0; m_pd = 1'b0;
        end else if (r) begin
            bnd = (m_ref == PER - 1);
            for (int i = 0; i < N; i++) begin
                if (ni[i] && !no[i])      m_phase[i] = (m_phase[i] + 2) % PER;
                else if (!ni[i] && no[i]) m_phase[i] = m_phase[i];
                else                      m_phase[i] = (m_phase[i] + 1) % PER;
            end
            m_ref = (m_ref + 1) % PER;
            m_pd  = bnd;
            if (bnd) begin
                any = 1'b0;
                for (int i = 0; i < N; i++) begin
                    rel       = (m_phase[i] - m_ref + PER) % PER;
                    nw        = (rel >= PER / 2);
                    m_chg[i]  = nw ^ m_snap[i];
                    m_snap[i] = nw;
                    any       = any | m_chg[i];
                end
                m_stable = any ? 0 : ((m_stable < SP) ? m_stable + 1 : SP);
                m_conv   = (m_stable == SP);
            end
        end else begin
            m_pd = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the edge; outputs sampled there too.
    task automatic cycle(input logic l, input logic r,
                         input logic [N*P-1:0] ini, input logic [N-1:0] ni);
        load = l; run = r; ini_phase = ini; nin = ni;
        @(posedge sclk);
        model_step(l, r, ini, ni);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [N*P-1:0] ini;
        re_n = 1'b0; run = 1'b0; load = 1'b0; ini_phase = '0; nin = '0;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        n_tests++;
        if ({phi_out, nout, state_changed, period_done, stable_cnt, converged} !==
            {{(N*P){1'b0}}, {N{1'b1}}, {N{1'b0}}, 1'b0, {SC_W{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_initial got phi=%h nout=%b chg=%b pd=%b sc=%0d cv=%b",
                     phi_out, nout, state_changed, period_done, stable_cnt, converged);
        end
        re_n = 1'b1;
        ini = P*N'($urandom());
        cycle(1'b1, 1'b0, ini, '0);
        for (int c = 0; c < 20; c++) cycle(1'b0, 1'b1, ini, N'($urandom()));
        #2 re_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (phi_out !== '0 || nout !== 4'b1111 || converged !== 1'b0 ||
            period_done !== 1'b0 || stable_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun got phi=%h nout=%b cv=%b pd=%b sc=%0d exp phi=0 nout=1111 cv=0 pd=0 sc=0",
                     phi_out, nout, converged, period_done, stable_cnt);
        end
        #1 re_n = 1'b1;
        // First boundary after release lands on the 16th run cycle.
        for (int c = 1; c <= PER; c++) begin
            cycle(1'b0, 1'b1, '0, N'($urandom()));
            n_tests++;
            if (period_done !== (c == PER)) begin
                n_fail++;
                $display("FAIL reset_first_period cyc %0d got pd=%b exp %b", c, period_done, c == PER);
            end
        end
    endtask

    task automatic test_free_run_convergence();
        logic [N*P-1:0] ini;
        ini = {4'd12, 4'd8, 4'd4, 4'd0};
        cycle(1'b1, 1'b0, ini, '0);
        for (int c = 1; c <= 3 * PER; c++) begin
            cycle(1'b0, 1'b1, ini, m_nout());
            n_tests++;
            if ({phi_out, nout, state_changed, period_done, stable_cnt, converged} !== m_all()) begin
                n_fail++;
                $display("FAIL free_run cyc %0d got %h exp %h",
                         c, {phi_out, nout, state_changed, period_done, stable_cnt, converged}, m_all());
            end
            n_tests++;
            if (phi_out[3*P +: P] !== P'((12 + c) % PER) || state_changed !== '0 ||
                period_done !== (c % PER == 0)) begin
                n_fail++;
                $display("FAIL free_run_rules cyc %0d got ph3=%0d chg=%b pd=%b exp ph3=%0d chg=0 pd=%b",
                         c, phi_out[3*P +: P], state_changed, period_done, (12 + c) % PER, c % PER == 0);
            end
            if (c % PER == 0) begin
                n_tests++;
                if (stable_cnt !== SC_W'(c / PER)) begin
                    n_fail++;
                    $display("FAIL stable_count cyc %0d got %0d exp %0d", c, stable_cnt, c / PER);
                end
            end
        end
        n_tests++;
        if (converged !== 1'b1) begin
            n_fail++;
            $display("FAIL converged_after_48 got %b exp 1", converged);
        end
        // Anti-coupling on neuron 2 for 8 cycles, then normal to the boundary.
        for (int c = 1; c <= PER; c++) begin
            cycle(1'b0, 1'b1, ini, (c <= 8) ? (m_nout() ^ 4'b0100) : m_nout());
            n_tests++;
            if ({phi_out, nout, state_changed, period_done, stable_cnt, converged} !== m_all()) begin
                n_fail++;
                $display("FAIL perturb_a cyc %0d got %h exp %h",
                         c, {phi_out, nout, state_changed, period_done, stable_cnt, converged}, m_all());
            end
        end
        // Neuron 2 held at nin=0 for a whole period: it stalls and flips.
        for (int c = 1; c <= PER; c++) begin
            cycle(1'b0, 1'b1, ini, m_nout() & 4'b1011);
            n_tests++;
            if ({phi_out, nout, state_changed, period_done, stable_cnt, converged} !== m_all()) begin
                n_fail++;
                $display("FAIL perturb_b cyc %0d got %h exp %h",
                         c, {phi_out, nout, state_changed, period_done, stable_cnt, converged}, m_all());
            end
        end
        n_tests++;
        if (state_changed !== 4'b0100 || stable_cnt !== '0 || converged !== 1'b0 || period_done !== 1'b1) begin
            n_fail++;
            $display("FAIL flip_detect got chg=%b sc=%0d cv=%b pd=%b exp chg=0100 sc=0 cv=0 pd=1",
                     state_changed, stable_cnt, converged, period_done);
        end
    endtask

    task automatic test_coupling();
        int exp_seq [4];
        logic [N*P-1:0] ini;
        exp_seq = '{10, 12, 14, 0};
        ini = {4'd0, 4'd8, 4'd0, 4'd8};
        cycle(1'b1, 1'b0, ini, '0);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b1, ini, 4'b0101);
            n_tests++;
            if (phi_out[P-1:0] !== P'(exp_seq[c]) || phi_out[2*P-1:P] !== '0 || phi_out !== m_phi()) begin
                n_fail++;
                $display("FAIL coupling step %0d got phi=%h exp ph0=%0d ph1=0 model=%h",
                         c, phi_out, exp_seq[c], m_phi());
            end
        end
    endtask

    task automatic test_priority_hold();
        logic [N*P-1:0] ini;
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, '0, N'($urandom()));
        ini = P*N'($urandom());
        cycle(1'b1, 1'b1, ini, N'($urandom()));
        n_tests++;
        if (phi_out !== ini || period_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_run got phi=%h pd=%b exp phi=%h pd=0", phi_out, period_done, ini);
        end
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b0, P*N'($urandom()), N'($urandom()));
            n_tests++;
            if (phi_out !== ini || period_done !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cyc %0d got phi=%h pd=%b exp phi=%h pd=0", c, phi_out, period_done, ini);
            end
        end
        // Reference was cleared by load and frozen by hold.
        for (int c = 1; c <= PER; c++) begin
            cycle(1'b0, 1'b1, ini, N'($urandom()));
            n_tests++;
            if (period_done !== (c == PER) || phi_out !== m_phi()) begin
                n_fail++;
                $display("FAIL ref_after_hold cyc %0d got pd=%b phi=%h exp pd=%b phi=%h",
                         c, period_done, phi_out, c == PER, m_phi());
            end
        end
    endtask

    task automatic test_load_boundary();
        logic [N*P-1:0] ini;
        logic [N*P-1:0] ini2;
        ini = P*N'($urandom());
        cycle(1'b1, 1'b0, ini, '0);
        for (int c = 0; c < 2 * PER - 1; c++) cycle(1'b0, 1'b1, ini, m_nout());
        n_tests++;
        if (stable_cnt !== SC_W'(1)) begin
            n_fail++;
            $display("FAIL pre_load_stable got %0d exp 1", stable_cnt);
        end
        ini2 = P*N'($urandom());
        cycle(1'b1, 1'b1, ini2, m_nout());
        n_tests++;
        if (period_done !== 1'b0 || stable_cnt !== '0 || converged !== 1'b0 || phi_out !== ini2) begin
            n_fail++;
            $display("FAIL load_at_boundary got pd=%b sc=%0d cv=%b phi=%h exp pd=0 sc=0 cv=0 phi=%h",
                     period_done, stable_cnt, converged, phi_out, ini2);
        end
        cycle(1'b0, 1'b0, ini2, '0);
        n_tests++;
        if (period_done !== 1'b0 || state_changed !== '0) begin
            n_fail++;
            $display("FAIL after_load_boundary got pd=%b chg=%b exp pd=0 chg=0", period_done, state_changed);
        end
    endtask

    task automatic test_random();
        logic l;
        logic r;
        for (int c = 0; c < 400; c++) begin
            l = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(l, r, P*N'($urandom()), N'($urandom()));
            n_tests++;
            if ({phi_out, nout, state_changed, period_done, stable_cnt, converged} !== m_all()) begin
                n_fail++;
                $display("FAIL random cyc %0d got %h exp %h",
                         c, {phi_out, nout, state_changed, period_done, stable_cnt, converged}, m_all());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_free_run_convergence();
        test_coupling();
        test_priority_hold();
        test_load_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
